alu_share_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one combinational 16-bit ALU (add/sub/and/or, carry/zero/overflow flags) between two requesters.
- Accepts one operation at a time over a valid/ready handshake and latches the operands onto the ALU input ports.
- Captures the ALU result and flags one cycle later, then returns them on a response channel tagged with the requester ID.
- Sits between the two datapath masters and the shared ALU instance.

---
 rtl/alu_share_arb.sv | 89 ++++++++
 tb/tb_alu_share_arb.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin arbiter sequencing two requesters onto one shared 16-bit ALU
module alu_share_arb #(
   parameter int W     = 16,
   parameter int SEL_W = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [W-1:0]     req0_opa,
   input  logic [W-1:0]     req0_opb,
   input  logic [SEL_W-1:0] req0_sel,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [W-1:0]     req1_opa,
   input  logic [W-1:0]     req1_opb,
   input  logic [SEL_W-1:0] req1_sel,
   output logic [W-1:0]     alu_opa,
   output logic [W-1:0]     alu_opb,
   output logic [SEL_W-1:0] alu_sel,
   input  logic [W-1:0]     alu_res,
   input  logic             alu_c,
   input  logic             alu_z,
   input  logic             alu_o,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [W-1:0]     rsp_res,
   output logic             rsp_c,
   output logic             rsp_z,
   output logic             rsp_o,
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t state, state_nxt;
   logic last_grant, grant, any_valid, accept;
   assign any_valid = req0_valid | req1_valid;
   assign grant     = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
   assign accept    = (state == IDLE) && any_valid;
   always_ff @(posedge clk) begin
      state <= !rst_n ? IDLE : state_nxt;
   end
   always_comb begin
      state_nxt = state == IDLE ? (any_valid ? EXEC : IDLE) :
                  state == EXEC ? RESP :
                  (state == RESP && !rsp_ready) ? RESP : IDLE;
   end
   always_comb begin
      busy       = state != IDLE;
      req0_ready = accept && !grant;
      req1_ready = accept && grant;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         alu_opa    <= '0;
         alu_opb    <= '0;
         alu_sel    <= '0;
         rsp_id     <= 1'b0;
         rsp_res    <= '0;
         rsp_c      <= 1'b0;
         rsp_z      <= 1'b0;
         rsp_o      <= 1'b0;
         rsp_valid  <= 1'b0;
         op_count   <= '0;
         last_grant <= 1'b1;
      end else begin
         if (accept) begin
            alu_opa    <= grant ? req1_opa : req0_opa;
            alu_opb    <= grant ? req1_opb : req0_opb;
            alu_sel    <= grant ? req1_sel : req0_sel;
            rsp_id     <= grant;
            last_grant <= grant;
         end
         if (state == EXEC) begin
            rsp_res   <= alu_res;
            rsp_c     <= alu_c;
            rsp_z     <= alu_z;
            rsp_o     <= alu_o;
            rsp_valid <= 1'b1;
         end
         if (state == RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: table vectors, hand sequences and randomized traffic against a behavioural model
module tb_alu_share_arb;
   logic clk = 1'b0, rst_n = 1'b0;
   logic req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
   logic [15:0] req0_opa = '0, req0_opb = '0, req1_opa = '0, req1_opb = '0;
   logic [1:0] req0_sel = '0, req1_sel = '0;
   logic req0_ready, req1_ready, rsp_valid, rsp_id, rsp_c, rsp_z, rsp_o, busy;
   logic [15:0] alu_opa, alu_opb, rsp_res, op_count, alu_res;
   logic [1:0] alu_sel;
   logic alu_c, alu_z, alu_o;
   logic s_req0_ready, s_req1_ready, s_rsp_valid, s_rsp_id, s_rsp_c, s_rsp_z, s_rsp_o, s_busy;
   logic [15:0] s_alu_opa, s_alu_opb, s_rsp_res;
   logic [1:0] s_alu_sel;
   logic [2:0] s_op_count;
   int checks = 0, failures = 0, exp_cnt = 0, prev_id = 1;

   always #5 clk = ~clk;

   // Reference ALU in integer arithmetic: {overflow, zero, carry/borrow, result}
   function automatic logic [18:0] ref_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] s);
      int ua, ub, sa, sb, u, sv;
      logic [15:0] r;
      logic c, o;
      ua = {16'b0, a};
      ub = {16'b0, b};
      sa = $signed(a);
      sb = $signed(b);
      case (s)
         2'd0: begin u = ua + ub; sv = sa + sb; end
         2'd1: begin u = ua - ub; sv = sa - sb; end
         2'd2: begin u = ua & ub; sv = 0; end
         default: begin u = ua | ub; sv = 0; end
      endcase
      r = 16'(u);
      c = (s < 2'd2) && (u > 65535 || u < 0);
      o = (s < 2'd2) && (sv > 32767 || sv < -32768);
      return {o, r == 16'h0, c, r};
   endfunction

   assign {alu_o, alu_z, alu_c, alu_res} = ref_op(alu_opa, alu_opb, alu_sel);

   alu_share_arb dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opa(req0_opa), .req0_opb(req0_opb), .req0_sel(req0_sel),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opa(req1_opa), .req1_opb(req1_opb), .req1_sel(req1_sel),
      .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_sel(alu_sel),
      .alu_res(alu_res), .alu_c(alu_c), .alu_z(alu_z), .alu_o(alu_o),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_res(rsp_res),
      .rsp_c(rsp_c), .rsp_z(rsp_z), .rsp_o(rsp_o), .busy(busy), .op_count(op_count)
   );

   // Narrow-counter copy on the same traffic, used to observe counter wrap quickly
   alu_share_arb #(.CNT_W(3)) u_small (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(s_req0_ready), .req0_opa(req0_opa), .req0_opb(req0_opb), .req0_sel(req0_sel),
      .req1_valid(req1_valid), .req1_ready(s_req1_ready), .req1_opa(req1_opa), .req1_opb(req1_opb), .req1_sel(req1_sel),
      .alu_opa(s_alu_opa), .alu_opb(s_alu_opb), .alu_sel(s_alu_sel),
      .alu_res(alu_res), .alu_c(alu_c), .alu_z(alu_z), .alu_o(alu_o),
      .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(s_rsp_id), .rsp_res(s_rsp_res),
      .rsp_c(s_rsp_c), .rsp_z(s_rsp_z), .rsp_o(s_rsp_o), .busy(s_busy), .op_count(s_op_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_count();
      chk("op_count", op_count, 32'(exp_cnt % 65536));
      chk("op_count_wrap3", s_op_count, 32'(exp_cnt % 8));
   endtask

   // pat: 1 = req0 only, 2 = req1 only, 3 = both; hold = cycles of rsp_ready low in RESP
   task automatic run_txn(input int pat, input logic [15:0] a0, input logic [15:0] b0, input logic [1:0] s0,
                          input logic [15:0] a1, input logic [15:0] b1, input logic [1:0] s1,
                          input int hold, input logic [18:0] exp0, input logic [18:0] exp1);
      int eg;
      logic [15:0] ga;
      logic [18:0] e;
      req0_valid = pat[0]; req0_opa = a0; req0_opb = b0; req0_sel = s0;
      req1_valid = pat[1]; req1_opa = a1; req1_opb = b1; req1_sel = s1;
      rsp_ready = (hold == 0);
      eg = (pat == 3) ? 1 - prev_id : (pat == 2 ? 1 : 0);
      ga = eg == 1 ? a1 : a0;
      e = eg == 1 ? exp1 : exp0;
      #1;
      chk("idle_ready0", req0_ready, 32'(eg == 0));
      chk("idle_ready1", req1_ready, 32'(eg == 1));
      chk("idle_busy", busy, 0);
      tick();
      prev_id = eg;
      chk("exec_busy", busy, 1);
      chk("exec_ready", {req0_ready, req1_ready}, 0);
      chk("exec_rsp_valid", rsp_valid, 0);
      chk("exec_alu_opa", alu_opa, ga);
      chk("exec_alu_sel", alu_sel, eg == 1 ? s1 : s0);
      if (eg == 0) begin req0_valid = 1'b0; req0_opa = 16'h1234; end
      else begin req1_valid = 1'b0; req1_opa = 16'h1234; end
      tick();
      chk("resp_valid", rsp_valid, 1);
      chk("resp_id", rsp_id, 32'(eg));
      chk("resp_data", {rsp_o, rsp_z, rsp_c, rsp_res}, e);
      chk("resp_alu_opa_held", alu_opa, ga);
      for (int i = 0; i < hold; i++) begin
         tick();
         chk("stall_valid", rsp_valid, 1);
         chk("stall_data", {rsp_o, rsp_z, rsp_c, rsp_res, rsp_id}, {e, 1'(eg)});
         chk("stall_ready", {req0_ready, req1_ready}, 0);
         chk_count();
      end
      rsp_ready = 1'b1;
      tick();
      exp_cnt++;
      chk("done_valid", rsp_valid, 0);
      chk("done_busy", busy, 0);
      chk("done_alu_opa_held", alu_opa, ga);
      chk_count();
   endtask

   task automatic reset_mid(input int stage);
      req0_valid = 1'b1; req1_valid = 1'b0;
      req0_opa = 16'h1111; req0_opb = 16'h2222; req0_sel = 2'd0;
      rsp_ready = 1'b0;
      tick();
      req0_valid = 1'b0;
      if (stage == 2) tick();
      chk("pre_reset_busy", busy, 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      exp_cnt = 0;
      prev_id = 1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_valid", rsp_valid, 0);
      chk("mid_rst_alu", {alu_opa, alu_opb, 14'b0, alu_sel}, 0);
      chk("mid_rst_rsp", {rsp_res, 12'b0, rsp_id, rsp_c, rsp_z, rsp_o}, 0);
      chk_count();
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      chk("mid_rst_grant0", {req0_ready, req1_ready}, 32'b10);
   endtask

   typedef struct {
      int pat;
      logic [15:0] a, b;
      logic [1:0] s;
      int hold;
      logic [18:0] exp;
   } vec_t;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t tbl[10];
      int last_acc, n_acc, cyc;
      tbl[0] = '{1, 16'h0003, 16'h0004, 2'd0, 0, 19'h00007};
      tbl[1] = '{3, 16'h0001, 16'h0002, 2'd1, 5, 19'h1FFFF};
      tbl[2] = '{1, 16'hFFFF, 16'h0001, 2'd0, 1, 19'h30000};
      tbl[3] = '{2, 16'h7FFF, 16'h0001, 2'd0, 0, 19'h48000};
      tbl[4] = '{1, 16'h8000, 16'h0001, 2'd1, 2, 19'h47FFF};
      tbl[5] = '{2, 16'h00FF, 16'h0F0F, 2'd2, 0, 19'h0000F};
      tbl[6] = '{1, 16'h00F0, 16'h000F, 2'd3, 0, 19'h000FF};
      tbl[7] = '{2, 16'h5555, 16'hAAAA, 2'd2, 1, 19'h20000};
      tbl[8] = '{3, 16'h1234, 16'h1234, 2'd1, 0, 19'h20000};
      tbl[9] = '{1, 16'h0002, 16'h0003, 2'd1, 0, 19'h1FFFF};
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      chk("rst_busy", busy, 0);
      chk("rst_valid", rsp_valid, 0);
      chk("rst_alu", {alu_opa, alu_opb, 14'b0, alu_sel}, 0);
      chk("rst_rsp", {rsp_res, 12'b0, rsp_id, rsp_c, rsp_z, rsp_o}, 0);
      chk("rst_ready", {req0_ready, req1_ready}, 0);
      chk_count();
      tick();
      chk("idle_ignore_rsp_ready", {busy, rsp_valid}, 0);
      chk_count();
      for (int i = 0; i < 10; i++)
         run_txn(tbl[i].pat, tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].s,
                 tbl[i].hold, tbl[i].exp, tbl[i].exp);
      // Both requesters continuously valid: strict alternation, accepts 3 clocks apart
      req0_valid = 1'b1; req0_opa = 16'h00FF; req0_opb = 16'h0F0F; req0_sel = 2'd2;
      req1_valid = 1'b1; req1_opa = 16'h00F0; req1_opb = 16'h000F; req1_sel = 2'd3;
      rsp_ready = 1'b1;
      #1;
      last_acc = -1;
      n_acc = 0;
      for (cyc = 0; cyc < 12; cyc++) begin
         if (req0_ready || req1_ready) begin
            chk("alt_grant", {req0_ready, req1_ready}, prev_id == 1 ? 32'b10 : 32'b01);
            if (last_acc >= 0) chk("alt_spacing", 32'(cyc - last_acc), 3);
            prev_id = 1 - prev_id;
            last_acc = cyc;
            n_acc++;
         end
         if (rsp_valid) begin
            chk("alt_res", rsp_res, rsp_id ? 16'h00FF : 16'h000F);
            exp_cnt++;
         end
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk("alt_accepts", 32'(n_acc), 4);
      chk("alt_idle", busy, 0);
      chk_count();
      reset_mid(1);
      run_txn(3, 16'h0005, 16'h0006, 2'd0, 16'h0009, 16'h0001, 2'd1, 0,
              ref_op(16'h0005, 16'h0006, 2'd0), ref_op(16'h0009, 16'h0001, 2'd1));
      reset_mid(2);
      run_txn(3, 16'h0005, 16'h0006, 2'd0, 16'h0009, 16'h0001, 2'd1, 1,
              ref_op(16'h0005, 16'h0006, 2'd0), ref_op(16'h0009, 16'h0001, 2'd1));
      for (int i = 0; i < 40; i++) begin
         logic [15:0] a0, b0, a1, b1;
         logic [1:0] s0, s1;
         a0 = 16'($urandom); b0 = 16'($urandom); s0 = 2'($urandom);
         a1 = 16'($urandom); b1 = 16'($urandom); s1 = 2'($urandom);
         run_txn(int'($urandom_range(1, 3)), a0, b0, s0, a1, b1, s1, int'($urandom_range(0, 3)),
                 ref_op(a0, b0, s0), ref_op(a1, b1, s1));
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();
      chk("final_idle", {busy, rsp_valid}, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
